// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM access sequencer.
// No logic: state encoding, operation type and default parameter values.
// No flow control of its own.
package mem_ctrl_pkg;

  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_SRAM_AW     = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Width of a counter able to hold 0..wc.
  function automatic int cnt_width(input int wc);
    return (wc < 1) ? 1 : $clog2(wc + 1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable up-counter timing how long the SRAM bus is held for one access.
// Latency: o_tc is combinational from the count; the count updates on each clk edge.
// Backpressure: none; the owner decides when to load and when to count.
module wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] TC = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Clear while loaded (idle), count one per cycle while the access runs.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count marks the last cycle the bus is held.
  assign o_tc = i_en && (r_cnt == TC);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle SRAM load/store sequencer for the MEM stage (optional MEM_STALL_CNT_EN adds stall_count).
// Latency: a request holds ready low for WAIT_CYCLES+1 cycles; ready returns in DONE with rdata valid.
// Backpressure: ready low freezes the pipeline; inputs are assumed stable and ignored during ACCESS.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_in,
  output logic               sram_we_n
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  state_t             r_state;
  op_t                r_op;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [31:0]        r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;

  logic w_req;
  logic w_ready;
  logic w_cnt_load;
  logic w_cnt_en;
  logic w_cnt_tc;

  assign w_req      = rd_en | wr_en;
  assign w_ready    = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign w_cnt_load = (r_state == IDLE);
  assign w_cnt_en   = (r_state == ACCESS);

  wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_tc   (w_cnt_tc)
  );

  // Sequencer: latch the request in IDLE, hold the bus through ACCESS, release it entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_RD;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // Store wins when both enables are set. Address wraps mod 2^32; byte offset dropped.
            r_op        <= wr_en ? OP_WR : OP_RD;
            r_sram_addr <= SRAM_AW'((address - BASE) >> 2);
            r_dq_out    <= wdata;
            r_we_n      <= ~wr_en;
            r_dq_oe     <= wr_en;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_cnt_tc) begin
            if (r_op == OP_RD) begin
              r_rdata <= sram_dq_in;
            end
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready       = w_ready;
  assign rdata       = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count frozen pipeline cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural asynchronous SRAM.
// Checks are taken 1 time unit after each rising edge, once inputs are settled.
// Inputs are held stable while ready is low, as the pipeline freeze would.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_in;
  logic        sram_we_n;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  mem_access_ctrl #(
    .WAIT_CYCLES (5),
    .BASE_ADDR   (1024),
    .SRAM_AW     (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, write captured while the strobe is low.
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access. With b2b set the call starts in the DONE cycle of the previous access.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input bit b2b, input logic [17:0] ea,
                            input logic ewe_n, input logic [31:0] erd);
    rd_en   = rd;
    wr_en   = wr;
    address = addr;
    wdata   = wd;
    #1;
    if (b2b) begin
      chk("b2b_done_ready", {31'd0, ready}, 32'd1);
      step();
    end
    chk("c0_ready", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("acc_ready", {31'd0, ready}, 32'd0);
      chk("acc_addr", {14'd0, sram_addr}, {14'd0, ea});
      chk("acc_we_n", {31'd0, sram_we_n}, {31'd0, ewe_n});
      chk("acc_oe", {31'd0, sram_dq_oe}, {31'd0, ~ewe_n});
      chk("acc_dq_out", sram_dq_out, wd);
    end
    step();
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("done_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("done_rdata", rdata, erd);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2]   = 32'hDEADBEEF;
    mem[255] = 32'h0BADF00D;

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", sram_dq_out, 32'd0);
    step();

    // Read 1032 -> word 2.
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 18'd2, 1'b1, 32'hDEADBEEF);
    step();
    chk("idle_after_read", {31'd0, ready}, 32'd1);

    // Write 1024 -> word 0, rdata untouched, then read it back.
    run_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, 18'd0, 1'b0, 32'hDEADBEEF);
    step();
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 18'd0, 1'b1, 32'h12345678);
    step();

    // Back-to-back: write 1028 then read 1028 with no idle gap.
    run_access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0, 18'd1, 1'b0, 32'h12345678);
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 18'd1, 1'b1, 32'hCAFEF00D);
    step();

    // Both enables: store wins, rdata unchanged; confirm by reading back.
    run_access(1'b1, 1'b1, 32'd1040, 32'hA5A50001, 1'b0, 18'd4, 1'b0, 32'hCAFEF00D);
    step();
    run_access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 18'd4, 1'b1, 32'hA5A50001);
    step();

    // Byte offset ignored: 1035 -> word 2.
    run_access(1'b1, 1'b0, 32'd1035, 32'd0, 1'b0, 18'd2, 1'b1, 32'hDEADBEEF);
    step();

    // Below base wraps: 1020 -> 0xFFFFFFFC -> word 0x3FFFF.
    run_access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, 18'h3FFFF, 1'b1, 32'h0BADF00D);
    step();

    // Reset in cycle 3 of a write.
    wr_en = 1'b1; address = 32'd1024; wdata = 32'h55555555;
    step();
    step();
    step();
    chk("mid_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    wr_en = 1'b0;
    step();
    chk("mrst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mrst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("mrst_rdata", rdata, 32'd0);
    chk("mrst_ready_idle", {31'd0, ready}, 32'd1);
    rd_en = 1'b1;
    #1;
    chk("mrst_ready_req", {31'd0, ready}, 32'd0);
    rd_en = 1'b0;
    rst = 1'b0;
    #1;
`ifdef MEM_STALL_CNT_EN
    chk("stall_after_rst", stall_count, 32'd0);
`endif
    step();
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    // Full read after the reset.
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 18'd2, 1'b1, 32'hDEADBEEF);
`ifdef MEM_STALL_CNT_EN
    chk("stall_one_read", stall_count, 32'd6);
`endif
    step();
    chk("final_rdata_hold", rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle external SRAM access sequencer for the MEM stage.
- Accepts one load or store per instruction from the EXE/MEM pipeline register outputs.
- Drives a single-port asynchronous SRAM and returns read data to the MEM/WB register path.
- Outputs `ready`; the pipeline drives all stage-register freeze inputs with `~ready`.

Parameters:
- WAIT_CYCLES, 5, number of cycles the SRAM bus is held per access (legal range 1..15).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request (Mem_R_en from the EXE/MEM register).
- wr_en  in  1  store request.
- address  in  32  byte address (ALU result).
- wdata  in  32  store data.
- rdata  out  32  last completed load data.
- ready  out  1  high = no access pending; pipeline may advance.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_dq_out  out  32  SRAM write data.
- sram_dq_oe  out  1  SRAM data-bus drive enable.
- sram_dq_in  in  32  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - state=IDLE, cnt=0, rdata=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - With rd_en|wr_en high, latch the operation (wr_en has priority if both are high).
  - Latch sram_addr = (address - BASE_ADDR)[SRAM_AW+1:2] and sram_dq_out = wdata.
  - For a write, set sram_we_n=0 and sram_dq_oe=1.
  - cnt<=0, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Bus signals are held constant.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: for a read, rdata<=sram_dq_in; set sram_we_n=1 and sram_dq_oe=0; go to DONE.
- DONE: go to IDLE unconditionally after one cycle.
- ready is combinational: (state==IDLE && !(rd_en|wr_en)) || state==DONE.
- Latency: a request first seen in cycle 0 keeps ready low for cycles 0..WAIT_CYCLES. ready is high in cycle WAIT_CYCLES+1 (DONE), with rdata already valid.
- Inputs must stay stable while ready is low; the pipeline freeze guarantees this. Input changes during ACCESS are ignored.
- Back-to-back requests: the next request is seen in IDLE the cycle after DONE. There is no bubble beyond the required access time.
- rdata holds its value across writes and idle periods. It changes only at read completion.
- Address arithmetic is modulo 2^32. Addresses below BASE_ADDR wrap; no checking is done. Byte offset bits [1:0] are ignored.
- Reset during ACCESS:
  - Next cycle is IDLE, sram_we_n=1, sram_dq_oe=0.
  - No DONE cycle occurs and rdata is cleared to 0.
  - A write in progress is abandoned.
- sram_we_n and sram_dq_oe are registered outputs, glitch-free.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_count (32 bits).
  - The counter increments every cycle that ready==0 and saturates at 0xFFFF_FFFF.
  - It is cleared by rst.
- When undefined: the port and the counter logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package mem_ctrl_pkg contains:
  - The state enum (IDLE, ACCESS, DONE).
  - The default WAIT_CYCLES and BASE_ADDR constants.
  - An op type (OP_RD, OP_WR).
- One natural sub-module, wait_counter: a loadable up-counter with terminal-count output, width $clog2(WAIT_CYCLES+1).
- The FSM and the bus registers stay in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles, then rd_en=wr_en=0 → ready=1, sram_we_n=1, sram_dq_oe=0, rdata=0.
- Read, WAIT_CYCLES=5: rd_en=1, address=1032, SRAM word 2 = 0xDEADBEEF → sram_addr=2 from cycle 1; ready low in cycles 0..5; ready=1 in cycle 6; rdata=0xDEADBEEF.
- Write: wr_en=1, address=1024, wdata=0x12345678 → sram_we_n=0, sram_dq_oe=1, sram_dq_out=0x12345678 for exactly 5 cycles (cycles 1..5); ready high in cycle 6; a later read of 1024 returns 0x12345678.
- Back-to-back: write to 1028 immediately followed by a read of 1028 → second access starts in cycle 7, ready high in cycle 13, rdata=written value.
- Both enables set: rd_en=wr_en=1, address=1040 → write performed (sram_we_n low 5 cycles); rdata unchanged.
- Reset mid-access: rst asserted in cycle 3 of a write → next cycle IDLE, sram_we_n=1, ready reflects inputs only; with MEM_STALL_CNT_EN, stall_count=0 after reset and =6 after one full read.
